// File: rtl/imem_responder_if.sv
// Fetch request/response channel between an instruction fetch initiator and imem_responder.
// Ports: req_valid/req_ready/req_addr carry the fetch address; rsp_valid/rsp_ready/rsp_data/rsp_err
//        return the instruction word or an error flag. master = initiator side, slave = responder side.
`timescale 1ns/1ps
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: serves one word fetch at a time from a loadable 2^AW x 32 array.
// Latency: accepted at edge N -> response valid after edge N+1+WAIT_CYCLES; one fetch per WAIT_CYCLES+3 cycles.
// Backpressure: response held stable until rsp_ready; no new request accepted until the cycle after the handshake.
// Ports: clk, rst (async, active-high), bus (slave side of imem_responder_if),
//        load_en/load_addr/load_data (program-load write port, any state), busy (state != IDLE).
`timescale 1ns/1ps
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          AW          = 10,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    imem_responder_if.slave     bus,
    input  logic                load_en,
    input  logic [AW-1:0]       load_addr,
    input  logic [31:0]         load_data,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    // One past the last valid byte address, widened so BASE_ADDR near the top cannot wrap.
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + (33'd4 << AW);

    logic [31:0]   mem [2**AW];
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          err_q;

    logic          req_err;
    logic [AW-1:0] req_idx;

    assign req_err = (bus.req_addr[1:0] != 2'b00)
                  || (bus.req_addr < BASE_ADDR)
                  || ({1'b0, bus.req_addr} >= ADDR_END);
    assign req_idx = AW'((bus.req_addr - BASE_ADDR) >> 2);

    // Program-load port; the array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // The first cycle in RESP (rsp_valid still low) is the capture slot: the array is read
    // there, so a load to the same index on that edge is seen only by later fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        idx_q         <= req_idx;
                        err_q         <= req_err;
                        cnt           <= CNT_INIT;
                        busy          <= 1'b1;
                        bus.req_ready <= 1'b0;
                        state         <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err_q;
                        bus.rsp_data  <= err_q ? 32'd0 : mem[idx_q];
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
